// File: rtl/pipe_scroller.sv
// rtl/pipe_scroller.sv - scrolls two pipe obstacles, spawns random gaps, counts passed pipes
module pipe_scroller #(
  parameter int unsigned TICK_DIV     = 833_333,
  parameter int unsigned STEP         = 2,
  parameter int unsigned SPAWN_X      = 720,
  parameter int unsigned PIPE2_INIT_X = 1080,
  parameter int unsigned BIRD_X       = 100
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        restart,
  input  logic        collision,
  output logic [10:0] pipe1_x,
  output logic [10:0] pipe1_y,
  output logic [10:0] pipe2_x,
  output logic [10:0] pipe2_y,
  output logic [7:0]  score,
  output logic        pipe_passed,
  output logic        running
);

  localparam logic [10:0] STEP_W    = 11'(STEP);
  localparam logic [10:0] SPAWN_W   = 11'(SPAWN_X);
  localparam logic [10:0] P2_INIT_W = 11'(PIPE2_INIT_X);
  localparam logic [10:0] BIRD_W    = 11'(BIRD_X);
  localparam logic [10:0] P1_INIT_Y = 11'd300;
  localparam logic [10:0] P2_INIT_Y = 11'd250;
  localparam logic [10:0] GAP_BASE  = 11'd160;
  localparam logic [19:0] TICK_LAST = 20'(TICK_DIV - 1);
  localparam logic [7:0]  LFSR_SEED = 8'hA5;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    FROZEN = 2'd2
  } state_t;

  state_t      state_q;
  logic [19:0] cnt_q;
  logic [7:0]  lfsr_q, lfsr_d;
  logic [10:0] p1_x_q, p1_y_q, p2_x_q, p2_y_q;
  logic [7:0]  score_q, score_d;
  logic        pipe_passed_q, running_q;

  logic        wrap1, wrap2, pass1, pass2;
  logic [10:0] p1_x_d, p1_y_d, p2_x_d, p2_y_d;
  logic [8:0]  score_sum;
  logic [7:0]  gap2;

  // Free-running Fibonacci LFSR, taps 8,6,5,4, shifting toward the MSB.
  assign lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
  assign gap2   = {lfsr_q[3:0], lfsr_q[7:4]};

  // Candidate positions for the next tick; only committed when the tick fires.
  always_comb begin
    wrap1  = p1_x_q < STEP_W;
    wrap2  = p2_x_q < STEP_W;
    p1_x_d = wrap1 ? SPAWN_W : (p1_x_q - STEP_W);
    p2_x_d = wrap2 ? SPAWN_W : (p2_x_q - STEP_W);
    p1_y_d = wrap1 ? (GAP_BASE + {3'b000, lfsr_q}) : p1_y_q;
    p2_y_d = wrap2 ? (GAP_BASE + {3'b000, gap2}) : p2_y_q;
    pass1  = !wrap1 && (p1_x_q >= BIRD_W) && (p1_x_d < BIRD_W);
    pass2  = !wrap2 && (p2_x_q >= BIRD_W) && (p2_x_d < BIRD_W);
    score_sum = {1'b0, score_q} + {8'd0, pass1} + {8'd0, pass2};
    score_d   = score_sum[8] ? 8'hFF : score_sum[7:0];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= 20'd0;
      lfsr_q        <= LFSR_SEED;
      p1_x_q        <= SPAWN_W;
      p1_y_q        <= P1_INIT_Y;
      p2_x_q        <= P2_INIT_W;
      p2_y_q        <= P2_INIT_Y;
      score_q       <= 8'd0;
      pipe_passed_q <= 1'b0;
      running_q     <= 1'b0;
    end else begin
      lfsr_q        <= lfsr_d;
      pipe_passed_q <= 1'b0;
      if (restart) begin
        state_q   <= IDLE;
        cnt_q     <= 20'd0;
        p1_x_q    <= SPAWN_W;
        p1_y_q    <= P1_INIT_Y;
        p2_x_q    <= P2_INIT_W;
        p2_y_q    <= P2_INIT_Y;
        score_q   <= 8'd0;
        running_q <= 1'b0;
      end else begin
        case (state_q)
          IDLE: begin
            cnt_q <= 20'd0;
            if (start) begin
              state_q   <= RUN;
              running_q <= 1'b1;
            end
          end
          RUN: begin
            // Collision beats a tick on the same edge; the counter keeps its value.
            if (collision) begin
              state_q   <= FROZEN;
              running_q <= 1'b0;
            end else if (cnt_q == TICK_LAST) begin
              cnt_q         <= 20'd0;
              p1_x_q        <= p1_x_d;
              p1_y_q        <= p1_y_d;
              p2_x_q        <= p2_x_d;
              p2_y_q        <= p2_y_d;
              score_q       <= score_d;
              pipe_passed_q <= pass1 | pass2;
            end else begin
              cnt_q <= cnt_q + 20'd1;
            end
          end
          FROZEN: begin
            cnt_q <= 20'd0;
          end
          default: begin
            state_q   <= IDLE;
            running_q <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pipe1_x     = p1_x_q;
  assign pipe1_y     = p1_y_q;
  assign pipe2_x     = p2_x_q;
  assign pipe2_y     = p2_y_q;
  assign score       = score_q;
  assign pipe_passed = pipe_passed_q;
  assign running     = running_q;

endmodule

// File: tb/tb_pipe_scroller.sv
// tb/tb_pipe_scroller.sv - directed self-checking bench for pipe_scroller
module tb_pipe_scroller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        restart = 1'b0;
  logic        collision = 1'b0;
  logic [10:0] p1x, p1y, p2x, p2y;
  logic [7:0]  score;
  logic        pp, running;

  int total = 0;
  int bad   = 0;

  logic [7:0] m_lfsr;
  logic [7:0] m_snap;

  always #5 clk = ~clk;

  pipe_scroller #(.TICK_DIV(4)) dut (
    .clk(clk), .reset(reset), .start(start), .restart(restart), .collision(collision),
    .pipe1_x(p1x), .pipe1_y(p1y), .pipe2_x(p2x), .pipe2_y(p2y),
    .score(score), .pipe_passed(pp), .running(running)
  );

  // Reference LFSR: taps 8,6,5,4 (bits 7,5,4,3), seed A5.
  always @(posedge clk or posedge reset) begin
    if (reset) m_lfsr <= 8'hA5;
    else       m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_init(input string tag);
    chk({tag, "_p1x"}, 32'(p1x), 32'd720);
    chk({tag, "_p1y"}, 32'(p1y), 32'd300);
    chk({tag, "_p2x"}, 32'(p2x), 32'd1080);
    chk({tag, "_p2y"}, 32'(p2y), 32'd250);
    chk({tag, "_score"}, 32'(score), 32'd0);
    chk({tag, "_running"}, 32'(running), 32'd0);
    chk({tag, "_passed"}, 32'(pp), 32'd0);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_p1(input logic [10:0] v);
    for (int i = 0; i < 3000 && p1x != v; i++) @(negedge clk);
    chk("wait_p1", 32'(p1x), 32'(v));
  endtask

  task automatic wait_p2(input logic [10:0] v);
    for (int i = 0; i < 3000 && p2x != v; i++) @(negedge clk);
    chk("wait_p2", 32'(p2x), 32'(v));
  endtask

  initial begin
    #12 reset = 1'b0;
    @(negedge clk);
    check_init("reset");
    cyc(20);
    chk("idle_p1x", 32'(p1x), 32'd720);
    chk("idle_running", 32'(running), 32'd0);

    // Scroll: start seen at edge N, first tick at N+4
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    chk("start_running", 32'(running), 32'd1);
    cyc(3);
    chk("pre_tick_p1x", 32'(p1x), 32'd720);
    cyc(1);
    chk("tick1_p1x", 32'(p1x), 32'd718);
    chk("tick1_p2x", 32'(p2x), 32'd1078);
    cyc(4);
    chk("tick2_p1x", 32'(p1x), 32'd716);
    chk("tick2_p2x", 32'(p2x), 32'd1076);
    chk("tick2_score", 32'(score), 32'd0);

    // Score: pipe1 100 -> 98
    wait_p1(11'd100);
    chk("pre_pass_score", 32'(score), 32'd0);
    cyc(3);
    chk("pre_pass_pulse", 32'(pp), 32'd0);
    cyc(1);
    chk("pass_p1x", 32'(p1x), 32'd98);
    chk("pass_pulse", 32'(pp), 32'd1);
    chk("pass_score", 32'(score), 32'd1);
    cyc(1);
    chk("pass_pulse_end", 32'(pp), 32'd0);
    chk("pass_score_hold", 32'(score), 32'd1);

    // Wrap: 0 -> 720 with gap from the LFSR value present before the edge
    wait_p1(11'd0);
    m_snap = m_lfsr;
    for (int i = 0; i < 8; i++) begin
      m_snap = m_lfsr;
      @(negedge clk);
      if (p1x != 11'd0) break;
    end
    chk("wrap_p1x", 32'(p1x), 32'd720);
    chk("wrap_p1y", 32'(p1y), 32'd160 + 32'(m_snap));
    chk("wrap_y_range", 32'(p1y >= 11'd160 && p1y <= 11'd415), 32'd1);
    chk("wrap_score", 32'(score), 32'd1);
    chk("wrap_pulse", 32'(pp), 32'd0);
    chk("wrap_p2y", 32'(p2y), 32'd250);

    // Saturation: preset score to 255, then pipe2 passes
    force dut.score_q = 8'd255;
    @(negedge clk);
    release dut.score_q;
    wait_p2(11'd100);
    chk("sat_pre_score", 32'(score), 32'd255);
    cyc(4);
    chk("sat_p2x", 32'(p2x), 32'd98);
    chk("sat_pulse", 32'(pp), 32'd1);
    chk("sat_score", 32'(score), 32'd255);

    // Collision on the tick edge: no movement, freeze
    cyc(3);
    collision = 1'b1;
    @(negedge clk);
    collision = 1'b0;
    chk("coll_p1x", 32'(p1x), 32'd460);
    chk("coll_p2x", 32'(p2x), 32'd98);
    chk("coll_running", 32'(running), 32'd0);
    cyc(50);
    chk("frozen_p1x", 32'(p1x), 32'd460);
    chk("frozen_p2x", 32'(p2x), 32'd98);
    chk("frozen_running", 32'(running), 32'd0);

    // Restart from FROZEN, then restart+start together, then start alone
    restart = 1'b1;
    @(negedge clk);
    check_init("restart");
    start = 1'b1;
    @(negedge clk);
    chk("rs_both_running", 32'(running), 32'd0);
    chk("rs_both_p1x", 32'(p1x), 32'd720);
    restart = 1'b0;
    @(negedge clk);
    start = 1'b0;
    chk("rs_start_running", 32'(running), 32'd1);
    cyc(3);
    chk("rs_pre_tick_p1x", 32'(p1x), 32'd720);
    cyc(1);
    chk("rs_tick_p1x", 32'(p1x), 32'd718);

    // Asynchronous reset between edges, mid-tick
    cyc(2);
    #2 reset = 1'b1;
    #1 check_init("areset");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("areset_hold_p1x", 32'(p1x), 32'd720);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc(3);
    chk("areset_pre_tick_p1x", 32'(p1x), 32'd720);
    cyc(1);
    chk("areset_tick_p1x", 32'(p1x), 32'd718);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_scroller.md
# pipe_scroller

Generates and scrolls the two pipe obstacles of the game. Drives the `pipe1_x/pipe1_y/pipe2_x/pipe2_y` coordinates consumed by the collision detector and the pipe renderer. Freezes on `collision` and re-initialises on `restart`. Also produces a pseudo-random gap height per spawned pipe and a pass-the-bird score.

## Interface
- `TICK_DIV`, 833_333: clock cycles per scroll tick (60 Hz at 50 MHz); bench uses 4.
- `STEP`, 2: pixels a pipe moves left per tick.
- `SPAWN_X`, 720: x (right edge) a wrapped pipe reappears at.
- `PIPE2_INIT_X`, 1080: initial x of pipe 2 (360 px behind pipe 1).
- `BIRD_X`, 100: fixed bird x used for scoring.
- `clk  in  1`: system clock.
- `reset  in  1`: **asynchronous, active-high**; forces every register to its reset value immediately.
- `start  in  1`: level; begins scrolling from IDLE.
- `restart  in  1`: level; returns to IDLE with initial positions.
- `collision  in  1`: level from collision detector; freezes play.
- `pipe1_x, pipe1_y, pipe2_x, pipe2_y  out  11`: pipe right-edge x and top-of-bottom-pipe y. The gap spans y-100..y.
- `score  out  8`: pipes passed, saturating at 255.
- `pipe_passed  out  1`: one-cycle pulse per pipe passing `BIRD_X`.
- `running  out  1`: high in RUN.

## Operation
- States:
  - IDLE (reset state): positions held at initial values.
  - RUN.
  - FROZEN.
- Transitions, evaluated at each posedge, in priority order:
  - `restart` in any state → IDLE.
  - IDLE: `start` → RUN. `collision` is ignored.
  - RUN: `collision` → FROZEN.
  - FROZEN: holds until `restart`.
- Entering IDLE loads initial values: pipe1 = (720, 300), pipe2 = (`PIPE2_INIT_X`, 250), score = 0, tick counter = 0. These are also the reset values; `pipe_passed` = 0, `running` = 0.
- Tick counter: 20 bits. Counts 0..`TICK_DIV`-1 only in RUN, then wraps to 0. Held at 0 in IDLE/FROZEN; holds its value on the FROZEN entry edge. The tick event is RUN, count == `TICK_DIV`-1, and `collision` == 0.
- On a tick, for each pipe independently:
  - If x < `STEP`: x ← `SPAWN_X` and y ← 160 + gap byte.
  - Otherwise x ← x − `STEP`; y unchanged.
- Gap bytes: pipe 1 uses `lfsr[7:0]`; pipe 2 uses `{lfsr[3:0], lfsr[7:4]}`. This keeps y within 160..415, which keeps the gap inside the wall limits (11..474).
- LFSR: 8-bit Fibonacci, taps 8,6,5,4, seed 8'hA5 on reset, shift toward MSB. It advances every clock in every state and is never reloaded by `restart`.
- Score: on a tick, a pipe whose old x ≥ `BIRD_X` and new x < `BIRD_X` counts as passed. `score` increments by the number passed that tick, saturating at 255, and `pipe_passed` pulses for that one cycle. A wrap never counts as a pass.
- Arithmetic is unsigned 11-bit. Because of the x < `STEP` guard, x never underflows.

## Timing
- All outputs are registered; there is no combinational path from inputs to outputs.
- `start` asserted at edge N: `running` = 1 after edge N. The first tick occurs at edge N+`TICK_DIV`, so positions change `TICK_DIV` cycles after start.
- `collision` high at the edge where a tick would fire: collision wins. There is no movement, the state goes to FROZEN, and positions are held from that edge.
- `restart` and `start` high together: IDLE and initial values, but `running` stays 0 while `restart` is high.
- `restart` held high: stays in IDLE. Once `restart` falls, `start` is honoured on the next edge.
- `reset` mid-tick: all outputs return to reset values asynchronously; the counter is cleared.
- `pipe_passed` is exactly one cycle wide and coincident with the `score` update.

## Test plan
- **Reset**: assert `reset` between clock edges → outputs immediately read (720,300), (1080,250), score 0, `running` 0. No movement with `start` low for 20 cycles.
- **Scroll**: `TICK_DIV`=4, pulse `start` → pipe1_x reads 718 four cycles later and 716 eight cycles later. pipe2_x moves in lockstep (1078, 1076).
- **Wrap**: run until pipe1_x = 0 → next tick gives pipe1_x = 720 and pipe1_y = 160 + gap byte derived from the LFSR sampled at that edge (bench models the LFSR). The value is within 160..415, and `score` does not change on the wrap.
- **Score**: pipe1_x goes 100 → 98 → `pipe_passed` high for exactly one cycle and `score` increments 0 → 1. Force score to 255, then cause another pass → score stays 255 and `pipe_passed` still pulses.
- **Collision**: assert `collision` on the tick-edge cycle → positions unchanged, `running` 0. 50 more cycles produce no movement.
- **Restart**: assert `restart` while frozen → initial positions and score 0 restored. `restart` and `start` together → IDLE. `start` after `restart` falls → RUN.
